// File: rtl/kbd_pkg.sv
// Shared constants for the PS/2 keyboard writer: prefix codes, event word layout and FSM encodings.
package kbd_pkg;

  localparam logic [7:0] KBD_CODE_EXT = 8'hE0;
  localparam logic [7:0] KBD_CODE_BRK = 8'hF0;

  localparam int EVT_W        = 10;
  localparam int EVT_CODE_LSB = 0;
  localparam int EVT_BRK_BIT  = 8;
  localparam int EVT_EXT_BIT  = 9;

  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_DATA   = 2'd1;
  localparam logic [1:0] RX_PARITY = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

  localparam logic [1:0] WR_IDLE  = 2'd0;
  localparam logic [1:0] WR_ENTRY = 2'd1;
  localparam logic [1:0] WR_HEAD  = 2'd2;

  function automatic logic [EVT_W-1:0] make_event(input logic ext, input logic brk,
                                                  input logic [7:0] code);
    logic [EVT_W-1:0] ev;
    ev                          = '0;
    ev[EVT_CODE_LSB +: 8]       = code;
    ev[EVT_BRK_BIT]             = brk;
    ev[EVT_EXT_BIT]             = ext;
    return ev;
  endfunction

endpackage

// File: rtl/ps2_kbd_writer_if.sv
// Port-B write bus between the keyboard writer (master) and the port-B arbiter (slave).
interface ps2_kbd_writer_if;
  logic        io_req;
  logic        io_gnt;
  logic        io_wren;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;

  modport master (output io_req, output io_wren, output io_addr, output io_wdata, input io_gnt);
  modport slave  (input io_req, input io_wren, input io_addr, input io_wdata, output io_gnt);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge sampling, frame FSM and idle timeout.
// PS2_PARITY_CHECK_EN enables odd-parity checking and the perr_o bad-frame pulse.
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o
`ifdef PS2_PARITY_CHECK_EN
  ,
  output logic       perr_o
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_prev_q;
  logic          fall, din, to_exp;
  logic [1:0]    st_q, st_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          vld_q, vld_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_q, par_d;
  logic          perr_q, perr_d;
`endif

  // Idle-high reset values keep reset release from looking like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign fall   = clk_prev_q & ~clk_sync_q[1];
  assign din    = data_sync_q[1];
  assign to_exp = (st_q != RX_IDLE) && (to_cnt_q == TW'(TIMEOUT_CYC));

  always_comb begin
    st_d      = st_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    vld_d     = 1'b0;
    to_cnt_d  = '0;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    if (!fall && st_q != RX_IDLE) to_cnt_d = to_cnt_q + TW'(1);
    if (to_exp && !fall) begin
      st_d     = RX_IDLE;
      to_cnt_d = '0;
    end else if (fall) begin
      case (st_q)
        RX_IDLE: begin
          if (!din) begin
            st_d      = RX_DATA;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) st_d = RX_PARITY;
        end
        RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = din;
`endif
          st_d  = RX_STOP;
        end
        default: begin
          st_d = RX_IDLE;
          if (din) begin
`ifdef PS2_PARITY_CHECK_EN
            if (^{shift_q, par_q}) begin
              byte_d = shift_q;
              vld_d  = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
`else
            byte_d = shift_q;
            vld_d  = 1'b1;
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= RX_IDLE;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      vld_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      st_q      <= st_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      vld_q     <= vld_d;
`ifdef PS2_PARITY_CHECK_EN
      perr_q    <= perr_d;
`endif
    end
  end

  // Datapath registers carry no reset; vld_q qualifies them.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    byte_q  <= byte_d;
`ifdef PS2_PARITY_CHECK_EN
    par_q   <= par_d;
`endif
  end

  assign byte_o     = byte_q;
  assign byte_vld_o = vld_q;
`ifdef PS2_PARITY_CHECK_EN
  assign perr_o     = perr_q;
`endif

endmodule

// File: rtl/ps2_kbd_writer.sv
// Keyboard event writer: folds E0/F0 prefixes into events, queues them, appends them to a memory ring.
// PS2_PARITY_CHECK_EN adds parity checking in the receiver and the perr_cnt port.
module ps2_kbd_writer
  import kbd_pkg::*;
#(
  parameter logic [31:0] KBD_BASE    = 32'h0000_F000,
  parameter int          RING_DEPTH  = 16,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  ps2_kbd_writer_if.master io,
  output logic [7:0]       head,
  output logic             overflow
`ifdef PS2_PARITY_CHECK_EN
  ,
  output logic [7:0]       perr_cnt
`endif
);

  localparam int            PW        = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]    HEAD_MASK = 8'(RING_DEPTH - 1);

  function automatic logic [31:0] entry_addr(input logic [7:0] h);
    return KBD_BASE + ((32'(h) + 32'd1) << 2);
  endfunction

  logic [7:0]       rx_byte;
  logic             rx_vld;
  logic             ext_q, brk_q, ovf_q;
  logic             is_prefix, push_req, push_ok, pop, full, empty;
  logic [EVT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [PW:0]      cnt_q;
  logic [1:0]       wst_q, wst_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]       head_q, head_d, head_nxt;
`ifdef PS2_PARITY_CHECK_EN
  logic             rx_perr;
  logic [7:0]       perr_q;
`endif

  ps2_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .byte_o    (rx_byte),
    .byte_vld_o(rx_vld)
`ifdef PS2_PARITY_CHECK_EN
    ,
    .perr_o    (rx_perr)
`endif
  );

  assign is_prefix = (rx_byte == KBD_CODE_EXT) || (rx_byte == KBD_CODE_BRK);
  assign push_req  = rx_vld && !is_prefix;
  assign full      = (cnt_q == FIFO_FULL);
  assign empty     = (cnt_q == '0);
  assign pop       = (wst_q == WR_ENTRY) && io.io_gnt;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push_req && (!full || pop);
  assign head_nxt  = (head_q + 8'd1) & HEAD_MASK;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      ovf_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (rx_vld) begin
        if (rx_byte == KBD_CODE_EXT) begin
          ext_q <= 1'b1;
        end else if (rx_byte == KBD_CODE_BRK) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end
      if (push_req && !push_ok) ovf_q <= 1'b1;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + (PW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= make_event(ext_q, brk_q, rx_byte);
  end

  // Write sequence: entry word first, then the head word that publishes it.
  always_comb begin
    wst_d   = wst_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    head_d  = head_q;
    case (wst_q)
      WR_IDLE: begin
        if (!empty) begin
          wst_d   = WR_ENTRY;
          req_d   = 1'b1;
          addr_d  = entry_addr(head_q);
          wdata_d = {{(32 - EVT_W){1'b0}}, fifo_mem[rd_ptr_q]};
        end
      end
      WR_ENTRY: begin
        if (io.io_gnt) begin
          wst_d   = WR_HEAD;
          addr_d  = KBD_BASE;
          wdata_d = {24'b0, head_nxt};
        end
      end
      WR_HEAD: begin
        if (io.io_gnt) begin
          head_d = head_nxt;
          if (!empty) begin
            wst_d   = WR_ENTRY;
            addr_d  = entry_addr(head_nxt);
            wdata_d = {{(32 - EVT_W){1'b0}}, fifo_mem[rd_ptr_q]};
          end else begin
            wst_d   = WR_IDLE;
            req_d   = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
          end
        end
      end
      default: begin
        wst_d   = WR_IDLE;
        req_d   = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wst_q   <= WR_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      head_q  <= '0;
    end else begin
      wst_q   <= wst_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      head_q  <= head_d;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr_q <= '0;
    end else if (rx_perr && perr_q != 8'hFF) begin
      perr_q <= perr_q + 8'd1;
    end
  end
  assign perr_cnt = perr_q;
`endif

  assign io.io_req   = req_q;
  assign io.io_wren  = req_q;
  assign io.io_addr  = addr_q;
  assign io.io_wdata = wdata_q;
  assign head        = head_q;
  assign overflow    = ovf_q;

endmodule
